// File: rtl/unidade_busca_pkg.sv
// Shared definitions for the two-byte instruction fetch unit.
package unidade_busca_pkg;

    // Default memory geometry.
    localparam int unsigned DATA_WIDTH_DEF  = 8;
    localparam int unsigned ADDR_WIDTH_DEF  = 6;
    // An instruction is two consecutive memory bytes.
    localparam int unsigned INSTR_WIDTH_DEF = 2 * DATA_WIDTH_DEF;

    // Fetch FSM state encoding.
    typedef logic [1:0] state_t;
    localparam state_t ST_REQ_HI = 2'd0;  // issue address of the first byte
    localparam state_t ST_REQ_LO = 2'd1;  // first byte returns, issue second address
    localparam state_t ST_CAP_LO = 2'd2;  // second byte returns, assemble instruction
    localparam state_t ST_VALID  = 2'd3;  // present instruction until accepted

endpackage

// File: rtl/unidade_busca_pc.sv
// Program counter: async reset, load beats increment, wraps modulo 2**ADDR_WIDTH.
module contador_pc #(
    parameter int unsigned ADDR_WIDTH = 6
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  load,
    input  logic [ADDR_WIDTH-1:0] load_value,
    input  logic                  inc,
    output logic [ADDR_WIDTH-1:0] count
);

    localparam logic [ADDR_WIDTH-1:0] One = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    logic [ADDR_WIDTH-1:0] r_count;

    // Counter register; natural overflow of the adder gives the wrap to 0.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_value;
        end else if (inc) begin
            r_count <= r_count + One;
        end
    end

    assign count = r_count;

endmodule

// File: rtl/unidade_busca.sv
// Fetch unit: reads two bytes per instruction from a synchronous memory
// and presents them with a valid/ready handshake.
module unidade_busca
    import unidade_busca_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                    clock,
    input  logic                    reset,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    input  logic [DATA_WIDTH-1:0]   mem_data,
    input  logic                    jump,
    input  logic [ADDR_WIDTH-1:0]   jump_addr,
    input  logic                    halt,
    output logic [2*DATA_WIDTH-1:0] instr,
    output logic [ADDR_WIDTH-1:0]   instr_pc,
    output logic                    instr_valid,
    input  logic                    instr_ready
);

    state_t                  r_state;
    logic [DATA_WIDTH-1:0]   r_hi;
    logic [2*DATA_WIDTH-1:0] r_instr;
    logic [ADDR_WIDTH-1:0]   r_instr_pc;
    logic                    r_valid;

    logic [ADDR_WIDTH-1:0]   w_pc;
    logic                    w_pc_inc;

    // PC advances when a byte address is consumed: starting a fetch or issuing the low byte.
    always_comb begin
        w_pc_inc = 1'b0;
        if (!jump) begin
            w_pc_inc = ((r_state == ST_REQ_HI) && !halt) || (r_state == ST_REQ_LO);
        end
    end

    contador_pc #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_pc (
        .clock      (clock),
        .reset      (reset),
        .load       (jump),
        .load_value (jump_addr),
        .inc        (w_pc_inc),
        .count      (w_pc)
    );

    // Fetch FSM and instruction holding registers; jump overrides everything.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= ST_REQ_HI;
            r_hi       <= '0;
            r_instr    <= '0;
            r_instr_pc <= '0;
            r_valid    <= 1'b0;
        end else if (jump) begin
            r_state <= ST_REQ_HI;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_REQ_HI: begin
                    if (!halt) begin
                        r_instr_pc <= w_pc;
                        r_state    <= ST_REQ_LO;
                    end
                end
                ST_REQ_LO: begin
                    r_hi    <= mem_data;
                    r_state <= ST_CAP_LO;
                end
                ST_CAP_LO: begin
                    r_instr <= {r_hi, mem_data};
                    r_valid <= 1'b1;
                    r_state <= ST_VALID;
                end
                default: begin
                    if (instr_ready) begin
                        r_valid <= 1'b0;
                        r_state <= ST_REQ_HI;
                    end
                end
            endcase
        end
    end

    assign mem_addr    = w_pc;
    assign instr       = r_instr;
    assign instr_pc    = r_instr_pc;
    assign instr_valid = r_valid;

endmodule

// File: tb/tb_unidade_busca.sv
// Directed self-checking bench for unidade_busca with a synchronous memory model.
module tb_unidade_busca;

    logic        clock = 1'b0;
    logic        reset;
    logic [5:0]  mem_addr;
    logic [7:0]  mem_data;
    logic        jump;
    logic [5:0]  jump_addr;
    logic        halt;
    logic [15:0] instr;
    logic [5:0]  instr_pc;
    logic        instr_valid;
    logic        instr_ready;

    logic [7:0]  mem [64];
    int          n_cmp = 0;
    int          n_err = 0;

    unidade_busca #(
        .DATA_WIDTH (8),
        .ADDR_WIDTH (6)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .jump        (jump),
        .jump_addr   (jump_addr),
        .halt        (halt),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready)
    );

    always #5 clock = ~clock;

    // Synchronous read memory: data for the sampled address appears after the edge.
    always @(posedge clock) mem_data <= mem[mem_addr];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; jump = 1'b0; jump_addr = '0; halt = 1'b0; instr_ready = 1'b1;
        tick(); tick(); tick();
        n_cmp++; if (mem_addr !== 6'd0) begin n_err++; $display("FAIL rst_addr got %0d want 0", mem_addr); end
        n_cmp++; if (instr !== 16'h0000) begin n_err++; $display("FAIL rst_instr got %h want 0000", instr); end
        n_cmp++; if (instr_pc !== 6'd0) begin n_err++; $display("FAIL rst_pc got %0d want 0", instr_pc); end
        n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %b want 0", instr_valid); end
        reset = 1'b0;
    endtask

    // Fetch at 0: valid rises on the third edge of the fetch, not earlier.
    task automatic test_basic();
        tick();
        n_cmp++; if (instr_valid !== 1'b0 || mem_addr !== 6'd1) begin
            n_err++; $display("FAIL basic_e0 got v=%b a=%0d want v=0 a=1", instr_valid, mem_addr); end
        tick();
        n_cmp++; if (instr_valid !== 1'b0 || mem_addr !== 6'd2) begin
            n_err++; $display("FAIL basic_e1 got v=%b a=%0d want v=0 a=2", instr_valid, mem_addr); end
        tick();
        n_cmp++; if (instr_valid !== 1'b1 || instr !== 16'h1234 || instr_pc !== 6'd0) begin
            n_err++; $display("FAIL basic_e2 got v=%b i=%h pc=%0d want v=1 i=1234 pc=0",
                              instr_valid, instr, instr_pc); end
        tick();
        n_cmp++; if (instr_valid !== 1'b0 || mem_addr !== 6'd2) begin
            n_err++; $display("FAIL basic_acc got v=%b a=%0d want v=0 a=2", instr_valid, mem_addr); end
    endtask

    // Consumer stalls 5 cycles; instruction must hold steady.
    task automatic test_stall();
        instr_ready = 1'b0;
        tick(); tick(); tick();
        for (int k = 0; k < 6; k++) begin
            n_cmp++; if (instr_valid !== 1'b1 || instr !== 16'hABCD || instr_pc !== 6'd2) begin
                n_err++; $display("FAIL stall_hold[%0d] got v=%b i=%h pc=%0d want v=1 i=abcd pc=2",
                                  k, instr_valid, instr, instr_pc); end
            if (k < 5) tick();
        end
        instr_ready = 1'b1;
        tick();
        n_cmp++; if (instr_valid !== 1'b0 || mem_addr !== 6'd4) begin
            n_err++; $display("FAIL stall_acc got v=%b a=%0d want v=0 a=4", instr_valid, mem_addr); end
        tick();
        n_cmp++; if (instr_pc !== 6'd4 || mem_addr !== 6'd5) begin
            n_err++; $display("FAIL stall_next got pc=%0d a=%0d want pc=4 a=5", instr_pc, mem_addr); end
    endtask

    // Jump to 62 while in REQ_LO; instruction wraps through 63 into address 0.
    task automatic test_jump_wrap();
        jump = 1'b1; jump_addr = 6'd62;
        tick();
        jump = 1'b0;
        n_cmp++; if (instr_valid !== 1'b0 || mem_addr !== 6'd62) begin
            n_err++; $display("FAIL jmp_load got v=%b a=%0d want v=0 a=62", instr_valid, mem_addr); end
        tick(); tick();
        n_cmp++; if (mem_addr !== 6'd0) begin n_err++; $display("FAIL jmp_wrap got a=%0d want 0", mem_addr); end
        tick();
        n_cmp++; if (instr_valid !== 1'b1 || instr !== 16'h5AC3 || instr_pc !== 6'd62) begin
            n_err++; $display("FAIL jmp_instr got v=%b i=%h pc=%0d want v=1 i=5ac3 pc=62",
                              instr_valid, instr, instr_pc); end
        tick(); tick();
        n_cmp++; if (instr_pc !== 6'd0 || mem_addr !== 6'd1) begin
            n_err++; $display("FAIL jmp_after got pc=%0d a=%0d want pc=0 a=1", instr_pc, mem_addr); end
        tick(); tick(); tick();
    endtask

    // Jump to 63 from REQ_HI with ready asserted: second byte comes from address 0.
    task automatic test_jump63();
        jump = 1'b1; jump_addr = 6'd63;
        tick();
        jump = 1'b0;
        tick(); tick(); tick();
        n_cmp++; if (instr_valid !== 1'b1 || instr !== 16'hC312 || instr_pc !== 6'd63) begin
            n_err++; $display("FAIL j63_instr got v=%b i=%h pc=%0d want v=1 i=c312 pc=63",
                              instr_valid, instr, instr_pc); end
        tick(); tick();
        n_cmp++; if (instr_pc !== 6'd1 || mem_addr !== 6'd2) begin
            n_err++; $display("FAIL j63_next got pc=%0d a=%0d want pc=1 a=2", instr_pc, mem_addr); end
        tick(); tick();
        n_cmp++; if (instr !== 16'h34AB) begin n_err++; $display("FAIL j63_follow got %h want 34ab", instr); end
        tick();
    endtask

    // Halt raised in CAP_LO: current instruction completes, then no new fetch starts.
    task automatic test_halt();
        tick(); tick();
        halt = 1'b1;
        tick();
        n_cmp++; if (instr_valid !== 1'b1 || instr !== 16'hCD0D || instr_pc !== 6'd3) begin
            n_err++; $display("FAIL halt_done got v=%b i=%h pc=%0d want v=1 i=cd0d pc=3",
                              instr_valid, instr, instr_pc); end
        tick();
        for (int k = 0; k < 3; k++) begin
            tick();
            n_cmp++; if (mem_addr !== 6'd5 || instr_valid !== 1'b0 || instr_pc !== 6'd3) begin
                n_err++; $display("FAIL halt_hold[%0d] got a=%0d v=%b pc=%0d want a=5 v=0 pc=3",
                                  k, mem_addr, instr_valid, instr_pc); end
        end
        halt = 1'b0;
        tick();
        n_cmp++; if (mem_addr !== 6'd6 || instr_pc !== 6'd5) begin
            n_err++; $display("FAIL halt_resume got a=%0d pc=%0d want a=6 pc=5", mem_addr, instr_pc); end
        instr_ready = 1'b0;
        tick(); tick();
        n_cmp++; if (instr_valid !== 1'b1 || instr !== 16'h1013) begin
            n_err++; $display("FAIL halt_next got v=%b i=%h want v=1 i=1013", instr_valid, instr); end
    endtask

    // Reset pulsed between edges while presenting an instruction.
    task automatic test_async_reset();
        #3 reset = 1'b1;
        #1;
        n_cmp++; if (instr_valid !== 1'b0 || mem_addr !== 6'd0 || instr !== 16'h0 || instr_pc !== 6'd0) begin
            n_err++; $display("FAIL arst got v=%b a=%0d i=%h pc=%0d want all 0",
                              instr_valid, mem_addr, instr, instr_pc); end
        #1 reset = 1'b0;
        instr_ready = 1'b1;
        tick();
        n_cmp++; if (instr_pc !== 6'd0 || mem_addr !== 6'd1) begin
            n_err++; $display("FAIL arst_restart got pc=%0d a=%0d want pc=0 a=1", instr_pc, mem_addr); end
        tick(); tick();
        n_cmp++; if (instr_valid !== 1'b1 || instr !== 16'h1234) begin
            n_err++; $display("FAIL arst_instr got v=%b i=%h want v=1 i=1234", instr_valid, instr); end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 8'(i * 3 + 1);
        mem[0] = 8'h12; mem[1] = 8'h34; mem[2] = 8'hAB; mem[3] = 8'hCD;
        mem[62] = 8'h5A; mem[63] = 8'hC3;
        test_reset();
        test_basic();
        test_stall();
        test_jump_wrap();
        test_jump63();
        test_halt();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/unidade_busca.md
UNIDADE_BUSCA -- requirements
Module: unidade_busca

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, 8, memory word width; ADDR_WIDTH, 6, memory address width.
REQ-002 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-003 clock  in  1  single clock; all state updates on rising edge; drives the memory read clock.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 mem_addr  out  ADDR_WIDTH  read address to the data memory; equals the PC register directly, no combinational input path.
REQ-006 mem_data  in  DATA_WIDTH  memory read data; valid one cycle after mem_addr is sampled.
REQ-007 jump  in  1  redirect request, sampled each rising edge.
REQ-008 jump_addr  in  ADDR_WIDTH  redirect target.
REQ-009 halt  in  1  suppress start of new fetches.
REQ-010 instr  out  2*DATA_WIDTH  assembled instruction {first byte, second byte}.
REQ-011 instr_pc  out  ADDR_WIDTH  address of the instruction's first byte.
REQ-012 instr_valid  out  1  instr and instr_pc valid.
REQ-013 instr_ready  in  1  consumer accepts instr when asserted with instr_valid.

Function
REQ-014 Each instruction SHALL consist of 2 consecutive memory bytes at pc and pc+1.
REQ-015 States SHALL be REQ_HI, REQ_LO, CAP_LO and VALID.
REQ-016 In REQ_HI, when halt=0, the block SHALL store pc into instr_pc, set pc to pc+1, and go to REQ_LO; when halt=1, it SHALL hold all state.
REQ-017 In REQ_LO, the block SHALL latch mem_data as the high byte, set pc to pc+1, and go to CAP_LO.
REQ-018 In CAP_LO, the block SHALL set instr to {high byte, mem_data}, set instr_valid to 1, and go to VALID.
REQ-019 In VALID, instr, instr_pc and instr_valid SHALL hold until instr_ready=1; on that edge instr_valid SHALL go to 0 and the state SHALL go to REQ_HI.
REQ-020 Latency SHALL be exactly 3 cycles from the REQ_HI edge that starts a fetch to instr_valid=1; maximum throughput SHALL be 1 instruction per 4 cycles.
REQ-021 pc arithmetic SHALL be modulo 2**ADDR_WIDTH, so the increment after address 63 is 0 and an instruction at 63 takes its second byte from 0.
REQ-022 jump=1 SHALL, in any state, set pc to jump_addr, set instr_valid to 0, discard any partial fetch, and go to REQ_HI.
REQ-023 jump SHALL have priority over instr_ready and halt on the same edge.
REQ-024 halt SHALL NOT abort an in-flight fetch; a fetch already in REQ_LO or CAP_LO SHALL complete and be presented.
REQ-025 instr SHALL remain stable while instr_valid=1 and instr_ready=0.

Reset
REQ-026 While reset=1, regardless of clock, outputs SHALL be: pc=0, mem_addr=0, instr=0, instr_pc=0, instr_valid=0; state SHALL be REQ_HI.
REQ-027 Reset asserted mid-fetch SHALL discard the partial instruction; after reset deasserts, fetching SHALL restart at address 0.

Structure
REQ-028 A shared package SHALL hold the state enumeration, the default DATA_WIDTH/ADDR_WIDTH values and the instruction width constant 2*DATA_WIDTH.
REQ-029 The PC SHALL be a sub-module contador_pc with async reset, load (jump) taking priority over increment, and a modulo-2**ADDR_WIDTH counter.

Verification
REQ-030 Memory bytes [0]=0x12, [1]=0x34, reset released, instr_ready=1 -> instr=0x1234, instr_pc=0, instr_valid high exactly 3 cycles after the first REQ_HI edge.
REQ-031 Memory bytes [2]=0xAB, [3]=0xCD, instr_ready held 0 for 5 cycles, then 1 -> instr=0xABCD stable throughout; next fetch starts at address 4.
REQ-032 jump=1 with jump_addr=62 asserted in REQ_LO -> partial fetch discarded; next instr_pc=62 with bytes from 62 and 63; the fetch after that is at instr_pc=0.
REQ-033 jump_addr=63 -> instr={mem[63], mem[0]}; the following instr_pc=1.
REQ-034 halt=1 asserted during CAP_LO -> the current instruction is still presented; no mem_addr change occurs while halted in REQ_HI; fetching resumes one cycle after halt=0.
REQ-035 reset pulsed asynchronously (between edges) while in VALID -> instr_valid=0 immediately; next instr_pc=0.
